// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler and the ALU it drives.
// Flag vectors are ordered {C, V, Z, N}.
package alu_pkg;

    localparam int ALU_W   = 7;
    localparam int ALU_OPW = 3;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    localparam logic [ALU_OPW-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_NOT = 3'd5;
    localparam logic [ALU_OPW-1:0] OP_SHL = 3'd6;
    localparam logic [ALU_OPW-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_op_scheduler_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_vld_o = |valid_i;
        gnt_id_o  = 1'b0;
        case (valid_i)
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one combinational ALU between two requesters: arbitrate, issue,
// capture the result and hand it back over a per-requester handshake.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int OPW   = ALU_OPW,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    input  logic [2*OPW-1:0] req_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_opsel,
    input  logic [W-1:0]     alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q;
    logic             id_q;
    logic             last_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [OPW-1:0]   op_q;
    logic [W-1:0]     res_q;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             gnt_vld;
    logic             gnt_id;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [OPW-1:0]   sel_op;

    rr_arb2 u_arb (
        .valid_i   (req_valid),
        .last_i    (last_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    assign sel_a  = gnt_id ? req_a[2*W-1:W]     : req_a[W-1:0];
    assign sel_b  = gnt_id ? req_b[2*W-1:W]     : req_b[W-1:0];
    assign sel_op = gnt_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
    assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        id_q    <= gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= alu_result;
                    flags_q <= alu_flags;
                    state_q <= RESP;
                end
                RESP: begin
                    // Only the owner's ready can retire the response.
                    if (rsp_ready[id_q]) begin
                        last_q  <= id_q;
                        cnt_q   <= cnt_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE && gnt_vld) ?
                        (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid  = (state_q == RESP) ?
                        (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opsel  = op_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: model ALU, vector table, directed corner
// sequences and random traffic against a transaction-level reference.
module tb_alu_op_scheduler;
    import alu_pkg::*;

    localparam int W     = 7;
    localparam int OPW   = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*W-1:0]   req_a;
    logic [2*W-1:0]   req_b;
    logic [2*OPW-1:0] req_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [W-1:0]     rsp_result;
    logic [3:0]       rsp_flags;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [OPW-1:0]   alu_opsel;
    logic [W-1:0]     alu_result;
    logic [3:0]       alu_flags;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    alu_op_scheduler #(.W(W), .OPW(OPW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opsel  (alu_opsel),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [OPW-1:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin r = {a[W-2:0], 1'b0}; c = a[W-1]; end
            default: begin r = {1'b0, a[W-1:1]}; c = a[0]; end
        endcase
        return {r, c, v, (r == '0), r[W-1]};
    endfunction

    always_comb {alu_result, alu_flags} = alu_fn(alu_a, alu_b, alu_opsel);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: one transaction at a time, response two edges after the
    // request is first seen, retired only by the owner's ready.
    int               m_phase;
    int               m_id;
    logic             m_last;
    logic [W-1:0]     m_a, m_b, m_res;
    logic [OPW-1:0]   m_op;
    logic [3:0]       m_flg;
    logic [CNT_W-1:0] m_cnt;

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return m_last ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic tick();
        int g;
        #1;
        g = pick(req_valid);
        check("req_ready", req_ready,
              (m_phase == 0 && g >= 0) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00);
        check("rsp_valid", rsp_valid,
              (m_phase == 2) ? ((m_id == 1) ? 2'b10 : 2'b01) : 2'b00);
        check("busy", busy, m_phase != 0);
        check("rsp_result", rsp_result, m_res);
        check("rsp_flags", rsp_flags, m_flg);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_opsel", alu_opsel, m_op);
        check("op_count", op_count, m_cnt);
        @(posedge clk);
        if (m_phase == 0 && g >= 0) begin
            m_id = g;
            m_a  = (g == 1) ? req_a[2*W-1:W] : req_a[W-1:0];
            m_b  = (g == 1) ? req_b[2*W-1:W] : req_b[W-1:0];
            m_op = (g == 1) ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
            m_phase = 1;
        end else if (m_phase == 1) begin
            {m_res, m_flg} = alu_fn(m_a, m_b, m_op);
            m_phase = 2;
        end else if (m_phase == 2 && rsp_ready[m_id]) begin
            m_last = (m_id == 1);
            m_cnt++;
            m_phase = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        check("rst busy", busy, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst alu_a", alu_a, 0);
        check("rst rsp_result", rsp_result, 0);
        check("rst op_count", op_count, 0);
        m_phase = 0; m_id = 0; m_last = 1'b1; m_cnt = '0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [OPW-1:0] op);
        if (id == 1) begin
            req_a[2*W-1:W] = a; req_b[2*W-1:W] = b;
            req_op[2*OPW-1:OPW] = op; req_valid = 2'b10;
        end else begin
            req_a[W-1:0] = a; req_b[W-1:0] = b;
            req_op[OPW-1:0] = op; req_valid = 2'b01;
        end
    endtask

    typedef struct {
        int             id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [OPW-1:0] op;
        logic [W-1:0]   res;
        logic [3:0]     flg;
    } vec_t;

    vec_t tbl[8];
    logic [W-1:0] held;

    initial begin
        tbl[0] = '{0, 7'h05, 7'h03, OP_ADD, 7'h08, 4'b0000};
        tbl[1] = '{1, 7'h7F, 7'h01, OP_ADD, 7'h00, 4'b1010};
        tbl[2] = '{0, 7'h03, 7'h05, OP_SUB, 7'h7E, 4'b1001};
        tbl[3] = '{1, 7'h55, 7'h0F, OP_AND, 7'h05, 4'b0000};
        tbl[4] = '{0, 7'h40, 7'h01, OP_OR,  7'h41, 4'b0001};
        tbl[5] = '{1, 7'h2A, 7'h2A, OP_XOR, 7'h00, 4'b0010};
        tbl[6] = '{0, 7'h3F, 7'h01, OP_ADD, 7'h40, 4'b0101};
        tbl[7] = '{1, 7'h41, 7'h00, OP_SHL, 7'h02, 4'b1000};

        req_a = '0; req_b = '0; req_op = '0;
        do_reset();

        foreach (tbl[i]) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op);
            rsp_ready = 2'b11;
            tick();
            req_valid = 2'b00;
            tick();
            #1;
            check("tbl rsp_valid", rsp_valid, (tbl[i].id == 1) ? 2'b10 : 2'b01);
            check("tbl result", rsp_result, tbl[i].res);
            check("tbl flags", rsp_flags, tbl[i].flg);
            tick();
        end
        check("tbl op_count", op_count, 8);

        // Both held valid: grants alternate starting with requester 0.
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_a = 14'($urandom); req_b = 14'($urandom);
            #1;
            check("rr order", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick(); tick(); tick();
        end

        // Backpressure with the wrong requester signalling ready.
        set_req(1, 7'h12, 7'h34, OP_SUB);
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b11;
        tick();
        held = rsp_result;
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) tick();
        check("bp rsp_valid", rsp_valid, 2'b10);
        check("bp held result", rsp_result, held);
        check("bp req_ready", req_ready, 2'b00);
        rsp_ready = 2'b10;
        tick();
        check("bp next grant", req_ready, 2'b01);

        // Reset while an operation is executing.
        req_valid = 2'b00;
        tick();
        set_req(1, 7'h11, 7'h22, OP_ADD);
        rsp_ready = 2'b11;
        tick();
        check("exec busy", busy, 1);
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) tick();

        // Random traffic, including drops and wrong-owner ready.
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom);
            req_a     = 14'($urandom);
            req_b     = 14'($urandom);
            req_op    = 6'($urandom);
            rsp_ready = 2'($urandom);
            tick();
        end

        // Counter wrap.
        do_reset();
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        for (int k = 0; k < 255; k++) begin
            req_a = 14'($urandom); req_op = 6'($urandom);
            tick(); tick(); tick();
        end
        check("count 255", op_count, 8'd255);
        tick(); tick(); tick();
        check("count wrap", op_count, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
